// File: rtl/jar_sram_nibble_burst_if.sv
// Purpose: narrow command/data bus that carries nibble beats to and from jar_sram_nibble_burst.
// Latency: none. The bundle holds wires only.
// Backpressure: none. The master watches busy and must not issue a new command while a burst is active.
// Signals:
//   op (2b)          command: 00 idle, 01 write beat, 10 read, 11 address beat
//   din (NW)         address or data beat from the master
//   dout (NW)        read data beat
//   dout_valid       dout carries a beat
//   busy             slave is not in IDLE
//   par_err          parity error on the current read beat
//   par_inv          exists only with JAR_SRAM_PARITY_EN; inverts the stored parity bit on commit
interface jar_sram_nibble_burst_if #(
    parameter int NW = 4
);
    logic [1:0]    op;
    logic [NW-1:0] din;
    logic [NW-1:0] dout;
    logic          dout_valid;
    logic          busy;
    logic          par_err;
`ifdef JAR_SRAM_PARITY_EN
    logic          par_inv;

    modport master (output op, din, par_inv, input dout, dout_valid, busy, par_err);
    modport slave  (input op, din, par_inv, output dout, dout_valid, busy, par_err);
`else
    modport master (output op, din, input dout, dout_valid, busy, par_err);
    modport slave  (input op, din, output dout, dout_valid, busy, par_err);
`endif
endinterface

// File: rtl/jar_sram_nibble_burst.sv
// Purpose: small SRAM reached over a nibble-wide burst bus. Address and write data arrive LSB slice
//          first, read data leaves LSB slice first, and an auto-incrementing pointer wraps at DEPTH.
// Latency: the first read beat appears 2 cycles after op=10 is sampled. A write commits on the cycle
//          its last beat is captured.
// Backpressure: none. A read burst runs to completion and ignores op. While a write or address
//          sequence is in progress, any other op aborts the sequence.
// Ports: clk, rst (synchronous, active-high), and bus (jar_sram_nibble_burst_if.slave).
// Option: define JAR_SRAM_PARITY_EN to get per-word even parity, the par_inv injection input, and a
//         live par_err output. Without it, par_err is tied to 0.
module jar_sram_nibble_burst #(
    parameter int NW = 4,
    parameter int DW = 8,
    parameter int AW = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    jar_sram_nibble_burst_if.slave  bus
);
    localparam int K     = DW / NW;
    localparam int A     = (AW + NW - 1) / NW;
    localparam int DEPTH = 1 << AW;
    localparam int MAXB  = (K > A) ? K : A;
    localparam int CW    = $clog2(MAXB + 1);
    localparam int AAW   = A * NW;

    typedef enum logic [2:0] {IDLE, ADDR, WDATA, RFETCH, RDATA} state_t;

    state_t         state, state_nxt;
    logic [AW-1:0]  ptr, ptr_nxt;
    logic [CW-1:0]  cnt, cnt_nxt;
    logic [DW-1:0]  wasm, wasm_nxt;
    logic [DW-1:0]  shift, shift_nxt;
    logic [AAW-1:0] aasm, aasm_nxt;
    logic [DW-1:0]  wr_cap;
    logic [AAW-1:0] addr_cap;
    logic           last_w, last_a, last_r;
    logic           mem_we;

    logic [DW-1:0]  mem [DEPTH];

    // Address slices beyond AW are accepted on the bus and then dropped.
    logic unused_addr_hi;
    assign unused_addr_hi = ^addr_cap;

    // Merge the incoming beat into the partial word or address at slice cnt.
    // A sequence that starts from IDLE builds on zero, so no stale bits from an
    // aborted sequence can leak into the new one.
    always_comb begin
        wr_cap   = (state == WDATA) ? wasm : '0;
        addr_cap = (state == ADDR)  ? aasm : '0;
        for (int i = 0; i < K; i++)
            if (cnt == CW'(i)) wr_cap[i*NW +: NW] = bus.din;
        for (int j = 0; j < A; j++)
            if (cnt == CW'(j)) addr_cap[j*NW +: NW] = bus.din;
    end

    assign last_w = (cnt == CW'(K - 1));
    assign last_a = (cnt == CW'(A - 1));
    assign last_r = (cnt == CW'(K - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            ptr   <= '0;
            cnt   <= '0;
            wasm  <= '0;
            aasm  <= '0;
            shift <= '0;
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
            cnt   <= cnt_nxt;
            wasm  <= wasm_nxt;
            aasm  <= aasm_nxt;
            shift <= shift_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        cnt_nxt   = cnt;
        wasm_nxt  = wasm;
        aasm_nxt  = aasm;
        shift_nxt = shift;
        mem_we    = 1'b0;

        case (state)
            IDLE: begin
                cnt_nxt = '0;
                case (bus.op)
                    2'b11: begin
                        if (last_a) begin
                            ptr_nxt = addr_cap[AW-1:0];
                        end else begin
                            aasm_nxt  = addr_cap;
                            cnt_nxt   = CW'(1);
                            state_nxt = ADDR;
                        end
                    end
                    2'b01: begin
                        if (last_w) begin
                            mem_we  = 1'b1;
                            ptr_nxt = ptr + AW'(1);
                        end else begin
                            wasm_nxt  = wr_cap;
                            cnt_nxt   = CW'(1);
                            state_nxt = WDATA;
                        end
                    end
                    2'b10:   state_nxt = RFETCH;
                    default: state_nxt = IDLE;
                endcase
            end

            ADDR: begin
                if (bus.op != 2'b11) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else if (last_a) begin
                    ptr_nxt   = addr_cap[AW-1:0];
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else begin
                    aasm_nxt = addr_cap;
                    cnt_nxt  = cnt + CW'(1);
                end
            end

            WDATA: begin
                if (bus.op != 2'b01) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else if (last_w) begin
                    mem_we    = 1'b1;
                    ptr_nxt   = ptr + AW'(1);
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else begin
                    wasm_nxt = wr_cap;
                    cnt_nxt  = cnt + CW'(1);
                end
            end

            RFETCH: begin
                shift_nxt = mem[ptr];
                cnt_nxt   = '0;
                state_nxt = RDATA;
            end

            RDATA: begin
                shift_nxt = shift >> NW;
                if (last_r) begin
                    ptr_nxt   = ptr + AW'(1);
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end

            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Memory contents survive reset. Reset only blocks a commit that would
    // otherwise happen on the same edge.
    always_ff @(posedge clk) begin
        if (mem_we && !rst)
            mem[ptr] <= wr_cap;
    end

    assign bus.dout       = (state == RDATA) ? shift[NW-1:0] : '0;
    assign bus.dout_valid = (state == RDATA);
    assign bus.busy       = (state != IDLE);

`ifdef JAR_SRAM_PARITY_EN
    logic par_mem [DEPTH];
    logic par_q;

    // The stored bit makes the total number of ones even. par_inv flips it so
    // that an error can be injected.
    always_ff @(posedge clk) begin
        if (mem_we && !rst)
            par_mem[ptr] <= (^wr_cap) ^ bus.par_inv;
    end

    // The check runs once at fetch time, and the result holds for the whole burst.
    always_ff @(posedge clk) begin
        if (rst)
            par_q <= 1'b0;
        else if (state == RFETCH)
            par_q <= (^mem[ptr]) ^ par_mem[ptr];
    end

    assign bus.par_err = (state == RDATA) && par_q;
`else
    assign bus.par_err = 1'b0;
`endif

endmodule

// File: tb/tb_jar_sram_nibble_burst.sv
// Purpose: directed self-checking bench for jar_sram_nibble_burst. It drives the default
//          8-bit/8-deep instance and a 16-bit/64-deep instance with two address beats.
// Latency: inputs change on the falling edge, and outputs are checked on the following falling edge.
// Backpressure: none. Every wait is a fixed number of clock ticks.
module tb_jar_sram_nibble_burst;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    jar_sram_nibble_burst_if #(.NW(4)) b1 ();
    jar_sram_nibble_burst_if #(.NW(4)) b2 ();

    jar_sram_nibble_burst #(.NW(4), .DW(8),  .AW(3)) u1 (.clk(clk), .rst(rst), .bus(b1.slave));
    jar_sram_nibble_burst #(.NW(4), .DW(16), .AW(6)) u2 (.clk(clk), .rst(rst), .bus(b2.slave));

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Apply one command to the small instance for one clock, then return at the next falling edge.
    task automatic tick(input logic [1:0] op, input logic [3:0] d);
        b1.op  = op;
        b1.din = d;
        @(negedge clk);
    endtask

    // Apply one command to the wide instance for one clock, then return at the next falling edge.
    task automatic tick2(input logic [1:0] op, input logic [3:0] d);
        b2.op  = op;
        b2.din = d;
        @(negedge clk);
    endtask

    task automatic wr8(input string tag, input logic [7:0] w);
        tick(2'b01, w[3:0]);
        chk({tag, "_busy_mid"}, 32'(b1.busy), 32'd1);
        tick(2'b01, w[7:4]);
        chk({tag, "_busy_done"}, 32'(b1.busy), 32'd0);
    endtask

    // During the burst, op=01 is driven on purpose: the read must ignore it.
    task automatic rd8(input string tag, input logic [7:0] w, input logic pe);
        logic [3:0] nib;
        tick(2'b10, 4'h0);
        chk({tag, "_fetch_vld"}, 32'(b1.dout_valid), 32'd0);
        chk({tag, "_fetch_busy"}, 32'(b1.busy), 32'd1);
        for (int i = 0; i < 2; i++) begin
            tick(2'b01, 4'hF);
            nib = w[i*4 +: 4];
            chk($sformatf("%s_beat%0d", tag, i), 32'(b1.dout), 32'(nib));
            chk($sformatf("%s_vld%0d", tag, i), 32'(b1.dout_valid), 32'd1);
            chk($sformatf("%s_perr%0d", tag, i), 32'(b1.par_err), 32'(pe));
        end
        tick(2'b00, 4'h0);
        chk({tag, "_end_vld"}, 32'(b1.dout_valid), 32'd0);
        chk({tag, "_end_dout"}, 32'(b1.dout), 32'd0);
        chk({tag, "_end_busy"}, 32'(b1.busy), 32'd0);
    endtask

    initial begin
        logic [15:0] w16;
        logic [3:0]  nib;

        b1.op = 2'b00; b1.din = 4'h0;
        b2.op = 2'b00; b2.din = 4'h0;
`ifdef JAR_SRAM_PARITY_EN
        b1.par_inv = 1'b0;
        b2.par_inv = 1'b0;
`endif
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("rst_busy",  32'(b1.busy),       32'd0);
        chk("rst_vld",   32'(b1.dout_valid), 32'd0);
        chk("rst_dout",  32'(b1.dout),       32'd0);
        chk("rst_perr",  32'(b1.par_err),    32'd0);
        chk("rst_busy2", 32'(b2.busy),       32'd0);
        rst = 1'b0;

        // Basic sequence: one address beat, a two-beat write, readback at address 5.
        tick(2'b11, 4'h5);
        chk("addr_single_beat_busy", 32'(b1.busy), 32'd0);
        wr8("t1w", 8'h3A);
        tick(2'b11, 4'h5);
        rd8("t1r", 8'h3A, 1'b0);

        // Pointer wraps from 7 to 0 and then to 1; the reads are contiguous.
        tick(2'b11, 4'h7);
        wr8("t2w7", 8'h11);
        wr8("t2w0", 8'h22);
        wr8("t2w1", 8'h3C);
        tick(2'b11, 4'h7);
        rd8("t2r7", 8'h11, 1'b0);
        rd8("t2r0", 8'h22, 1'b0);
        rd8("t2r1", 8'h3C, 1'b0);

        // A write aborted by op=10 leaves memory and ptr unchanged and starts no read.
        tick(2'b11, 4'h2);
        wr8("t3w", 8'h77);
        tick(2'b11, 4'h2);
        tick(2'b01, 4'hF);
        chk("t3_busy_wr", 32'(b1.busy), 32'd1);
        tick(2'b10, 4'h0);
        chk("t3_abort_busy", 32'(b1.busy), 32'd0);
        chk("t3_abort_vld",  32'(b1.dout_valid), 32'd0);
        tick(2'b00, 4'h0);
        chk("t3_noread_busy", 32'(b1.busy), 32'd0);
        chk("t3_noread_vld",  32'(b1.dout_valid), 32'd0);
        rd8("t3r", 8'h77, 1'b0);

        // Reset on the second read beat truncates the burst and clears ptr.
        tick(2'b11, 4'h5);
        tick(2'b10, 4'h0);
        tick(2'b00, 4'h0);
        chk("t4_beat0", 32'(b1.dout), 32'hA);
        tick(2'b00, 4'h0);
        chk("t4_beat1", 32'(b1.dout), 32'h3);
        rst = 1'b1;
        tick(2'b00, 4'h0);
        rst = 1'b0;
        chk("t4_rst_vld",  32'(b1.dout_valid), 32'd0);
        chk("t4_rst_busy", 32'(b1.busy), 32'd0);
        chk("t4_rst_dout", 32'(b1.dout), 32'd0);
        rd8("t4r_ptr0", 8'h22, 1'b0);

        // Reset in the middle of a write: no commit, and ptr returns to 0.
        tick(2'b01, 4'h5);
        rst = 1'b1;
        tick(2'b01, 4'h9);
        rst = 1'b0;
        chk("t4w_rst_busy", 32'(b1.busy), 32'd0);
        rd8("t4w_r", 8'h22, 1'b0);

`ifdef JAR_SRAM_PARITY_EN
        // Parity error injection, then a clean rewrite of the same word.
        tick(2'b11, 4'h4);
        b1.par_inv = 1'b1;
        wr8("t5w_inv", 8'h5A);
        b1.par_inv = 1'b0;
        tick(2'b11, 4'h4);
        rd8("t5r_inv", 8'h5A, 1'b1);
        tick(2'b11, 4'h4);
        wr8("t5w_ok", 8'h5A);
        tick(2'b11, 4'h4);
        rd8("t5r_ok", 8'h5A, 1'b0);
`endif

        // Wide instance: two address beats, four-beat write and read.
        tick2(2'b11, 4'h5);
        chk("t6_addr_busy", 32'(b2.busy), 32'd1);
        tick2(2'b11, 4'h2);
        chk("t6_addr_done", 32'(b2.busy), 32'd0);
        w16 = 16'hBEEF;
        for (int i = 0; i < 4; i++) begin
            tick2(2'b01, w16[i*4 +: 4]);
            chk($sformatf("t6_wbusy%0d", i), 32'(b2.busy), (i == 3) ? 32'd0 : 32'd1);
        end
        // An address sequence aborted by op=10 must not start a read.
        tick2(2'b11, 4'h1);
        chk("t6_abort_busy_mid", 32'(b2.busy), 32'd1);
        tick2(2'b10, 4'h0);
        chk("t6_abort_busy", 32'(b2.busy), 32'd0);
        tick2(2'b00, 4'h0);
        chk("t6_abort_noread", 32'(b2.dout_valid), 32'd0);
        // The address beats are 0x5 and 0x6, i.e. 0x65. Bit 6 exceeds AW, so the address is 0x25.
        tick2(2'b11, 4'h5);
        tick2(2'b11, 4'h6);
        tick2(2'b10, 4'h0);
        chk("t6_fetch_vld", 32'(b2.dout_valid), 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick2(2'b00, 4'h0);
            nib = w16[i*4 +: 4];
            chk($sformatf("t6_rbeat%0d", i), 32'(b2.dout), 32'(nib));
            chk($sformatf("t6_rvld%0d", i), 32'(b2.dout_valid), 32'd1);
            chk($sformatf("t6_rperr%0d", i), 32'(b2.par_err), 32'd0);
        end
        tick2(2'b00, 4'h0);
        chk("t6_end_vld",  32'(b2.dout_valid), 32'd0);
        chk("t6_end_busy", 32'(b2.busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/jar_sram_nibble_burst.md
JAR_SRAM_NIBBLE_BURST -- requirements
Module: jar_sram_nibble_burst

Interface
REQ-001 SHALL have parameter NW, default 4: nibble (bus) width in bits.
REQ-002 SHALL have parameter DW, default 8: word width; multiple of NW; K = DW/NW beats per word.
REQ-003 SHALL have parameter AW, default 3: address width; DEPTH = 2**AW words; A = ceil(AW/NW) address beats.
REQ-004 SHALL have port clk, input, 1: clock, all logic on rising edge.
REQ-005 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-006 SHALL have port op, input, 2: command (00 idle, 01 write, 10 read, 11 address).
REQ-007 SHALL have port din, input, NW: shared address/data beat.
REQ-008 SHALL have port dout, output, NW: read data beat.
REQ-009 SHALL have port dout_valid, output, 1: dout carries a valid beat.
REQ-010 SHALL have port busy, output, 1: FSM not in IDLE.
REQ-011 SHALL have port par_err, output, 1: parity error on current read beat (Configuration).

Function
REQ-012 SHALL implement FSM states IDLE, ADDR, WDATA, RFETCH, RDATA; sampled op selects the action each cycle.
REQ-013 SHALL, from IDLE with op=11, load din into address pointer ptr bits [NW-1:0] and enter ADDR if A>1, else stay IDLE; later beats fill successive higher NW-bit slices; ADDR returns to IDLE after beat A; bits beyond AW are ignored.
REQ-014 SHALL, from IDLE with op=01, capture din as beat 0 (word bits [NW-1:0]) and enter WDATA; each further op=01 cycle captures the next higher slice.
REQ-015 SHALL, on the cycle beat K-1 is captured, write the assembled word to mem[ptr], increment ptr modulo DEPTH, and return to IDLE.
REQ-016 SHALL, from IDLE with op=10, enter RFETCH; the next cycle latches mem[ptr] into an output shift register and enters RDATA.
REQ-017 SHALL, in RDATA, drive dout with beat i (LSB slice first) and dout_valid=1 for K consecutive cycles regardless of op, then increment ptr modulo DEPTH and return to IDLE.
REQ-018 SHALL give first-beat read latency of exactly 2 cycles after the op=10 sample.
REQ-019 SHALL drive dout=0 and dout_valid=0 whenever not in RDATA.
REQ-020 SHALL, in WDATA or ADDR, abort if op differs from the state's op: discard the partial word or address, leave mem and ptr unchanged, go to IDLE; the aborting op is not started that cycle.
REQ-021 SHALL ignore op in RFETCH and RDATA: reads are never aborted.
REQ-022 SHALL wrap ptr from DEPTH-1 to 0, making back-to-back bursts contiguous and circular.
REQ-023 SHALL not initialise memory contents; a read of an unwritten word returns X in simulation.

Reset
REQ-024 SHALL, on rst=1 at a clock edge, go to IDLE, clear ptr, beat counter, shift and assembly registers, dout, dout_valid, busy, par_err; mem keeps its contents.
REQ-025 SHALL give rst priority over any op, including mid-write (word not committed) and mid-read (burst truncated).

Configuration
REQ-026 SHALL, with macro JAR_SRAM_PARITY_EN defined, store one even-parity bit per word, computed at write commit.
REQ-027 SHALL, with JAR_SRAM_PARITY_EN defined, recompute parity at RFETCH and hold par_err=1 on every RDATA beat of a mismatching word.
REQ-028 SHALL, with JAR_SRAM_PARITY_EN defined, add input port par_inv, 1: inverts the stored parity bit for a word committed while par_inv=1, for error injection.
REQ-029 SHALL, without JAR_SRAM_PARITY_EN, have no parity storage and no par_inv port, and tie par_err to 0.

Verification
REQ-030 SHALL cover: rst; op=11 din=5; op=01 din=A, op=01 din=3; op=11 din=5; op=10 -> 2 cycles later dout=A then 3, dout_valid=1 for 2 cycles.
REQ-031 SHALL cover: ptr=7, write 0x11 then 0x22 -> mem[7]=0x11, mem[0]=0x22, ptr=1 (wrap).
REQ-032 SHALL cover: op=01 din=F, then op=10 -> write aborted, mem and ptr unchanged, FSM in IDLE, no read started.
REQ-033 SHALL cover: rst asserted on second RDATA beat -> next cycle dout_valid=0, busy=0, ptr=0.
REQ-034 SHALL cover: with JAR_SRAM_PARITY_EN, write 0x5A with par_inv=1, read it back -> dout 0xA then 0x5 with par_err=1 on both beats; rewrite with par_inv=0 -> par_err=0.
REQ-035 SHALL cover: NW=4, DW=16, AW=6 -> two address beats, four-beat write, four-beat read, data matches.
